// File: rtl/akuma_motion_ctrl.sv
// Per-frame motion/animation controller for Akuma: state machine, walk/jump position tracking,
// sprite code and attack hitbox flag. All updates happen on vga_clk edges qualified by frame_tick.
module akuma_motion_ctrl #(
   parameter int X_INIT          = 100,
   parameter int GROUND_Y        = 300,
   parameter int X_MIN           = 0,
   parameter int X_MAX           = 560,
   parameter int WALK_STEP       = 2,
   parameter int JUMP_V0         = 12,
   parameter int GRAVITY         = 1,
   parameter int PUNCH_FRAMES    = 12,
   parameter int PUNCH_HIT_START = 4,
   parameter int PUNCH_HIT_END   = 8
) (
   input  logic       vga_clk,
   input  logic       reset_n,
   input  logic       frame_tick,
   input  logic       key_left,
   input  logic       key_right,
   input  logic       key_up,
   input  logic       key_down,
   input  logic       key_punch,
   input  logic       health_zero,
   output logic [2:0] sprite,
   output logic [9:0] AkumaX,
   output logic [9:0] AkumaY,
   output logic       attack_active,
   output logic       airborne
);

   typedef enum logic [2:0] {
      STAND  = 3'd0,
      PUNCH  = 3'd1,
      JUMP   = 3'd2,
      CROUCH = 3'd3,
      WALK_L = 3'd4,
      WALK_R = 3'd5,
      DEAD   = 3'd6,
      JATK   = 3'd7
   } state_t;

   localparam logic signed [11:0] X_MIN_S    = 12'(X_MIN);
   localparam logic signed [11:0] X_MAX_S    = 12'(X_MAX);
   localparam logic signed [11:0] GROUND_S   = 12'(GROUND_Y);
   localparam logic signed [11:0] STEP_S     = 12'(WALK_STEP);
   localparam logic        [9:0]  X_INIT_10  = 10'(X_INIT);
   localparam logic        [9:0]  GROUND_10  = 10'(GROUND_Y);
   localparam logic signed [7:0]  V0_S       = 8'(JUMP_V0);
   localparam logic signed [7:0]  GRAV_S     = 8'(GRAVITY);
   localparam logic        [7:0]  PUNCH_LAST = 8'(PUNCH_FRAMES - 1);
   localparam logic        [7:0]  HIT_START  = 8'(PUNCH_HIT_START);
   localparam logic        [7:0]  HIT_END    = 8'(PUNCH_HIT_END);

   state_t            state_q, state_d;
   logic        [9:0] x_q, x_d;
   logic        [9:0] y_q, y_d;
   logic signed [7:0] vel_q, vel_d;
   logic        [7:0] count_q, count_d;
   logic signed [1:0] drift_q, drift_d;
   logic              air_q, air_d;

   logic signed [11:0] x_ext;
   logic signed [11:0] y_ext;
   logic signed [11:0] vel_ext;
   logic signed [11:0] y_fall;
   logic signed [11:0] drift_step;
   logic               land;
   logic        [9:0]  y_bal;
   logic signed [7:0]  vel_bal;
   logic               air_bal;

   // Saturate a widened X back into the playfield; the 12-bit math keeps
   // steps past either edge from wrapping before the clamp sees them.
   function automatic logic [9:0] clamp_x(input logic signed [11:0] pos);
      logic signed [11:0] lim;
      lim = pos;
      if (pos < X_MIN_S) begin
         lim = X_MIN_S;
      end else if (pos > X_MAX_S) begin
         lim = X_MAX_S;
      end
      return 10'(lim);
   endfunction

   assign x_ext   = {2'b00, x_q};
   assign y_ext   = {2'b00, y_q};
   assign vel_ext = {{4{vel_q[7]}}, vel_q};
   assign y_fall  = y_ext - vel_ext;
   assign land    = (y_fall >= GROUND_S);

   // One frame of ballistics, shared by JUMP, JATK and an airborne DEAD.
   always_comb begin
      y_bal   = y_q;
      vel_bal = vel_q;
      air_bal = air_q;
      if (land) begin
         y_bal   = GROUND_10;
         vel_bal = 8'sd0;
         air_bal = 1'b0;
      end else begin
         y_bal   = 10'(y_fall);
         vel_bal = vel_q - GRAV_S;
         air_bal = 1'b1;
      end
   end

   always_comb begin
      drift_step = 12'sd0;
      case (drift_q)
         2'b01:   drift_step = STEP_S;
         2'b11:   drift_step = -STEP_S;
         default: drift_step = 12'sd0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      vel_d   = vel_q;
      count_d = count_q;
      drift_d = drift_q;
      air_d   = air_q;
      if (frame_tick) begin
         case (state_q)
            STAND, CROUCH, WALK_L, WALK_R: begin
               if (health_zero) begin
                  state_d = DEAD;
               end else if (key_up) begin
                  state_d = JUMP;
                  vel_d   = V0_S;
                  air_d   = 1'b1;
                  if (key_left ^ key_right) begin
                     drift_d = key_right ? 2'b01 : 2'b11;
                  end else begin
                     drift_d = 2'b00;
                  end
               end else if (key_punch) begin
                  state_d = PUNCH;
                  count_d = 8'd0;
               end else if (key_down) begin
                  state_d = CROUCH;
               end else if (key_left ^ key_right) begin
                  if (key_left) begin
                     state_d = WALK_L;
                     x_d     = clamp_x(x_ext - STEP_S);
                  end else begin
                     state_d = WALK_R;
                     x_d     = clamp_x(x_ext + STEP_S);
                  end
               end else begin
                  state_d = STAND;
               end
            end
            PUNCH: begin
               if (health_zero) begin
                  state_d = DEAD;
               end else if (count_q >= PUNCH_LAST) begin
                  state_d = STAND;
               end else begin
                  count_d = count_q + 8'd1;
               end
            end
            JUMP, JATK: begin
               y_d   = y_bal;
               vel_d = vel_bal;
               air_d = air_bal;
               x_d   = clamp_x(x_ext + drift_step);
               if (health_zero) begin
                  state_d = DEAD;
               end else if (land) begin
                  state_d = STAND;
               end else if ((state_q == JATK) || key_punch) begin
                  state_d = JATK;
               end else begin
                  state_d = JUMP;
               end
            end
            DEAD: begin
               if (air_q) begin
                  y_d   = y_bal;
                  vel_d = vel_bal;
                  air_d = air_bal;
               end
            end
            default: state_d = STAND;
         endcase
      end
   end

   always_ff @(posedge vga_clk) begin
      if (!reset_n) begin
         state_q <= STAND;
         x_q     <= X_INIT_10;
         y_q     <= GROUND_10;
         vel_q   <= 8'sd0;
         count_q <= 8'd0;
         drift_q <= 2'b00;
         air_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         vel_q   <= vel_d;
         count_q <= count_d;
         drift_q <= drift_d;
         air_q   <= air_d;
      end
   end

   assign sprite        = state_q;
   assign AkumaX        = x_q;
   assign AkumaY        = y_q;
   assign airborne      = air_q;
   assign attack_active = (state_q == JATK) ||
                          ((state_q == PUNCH) && (count_q >= HIT_START) && (count_q <= HIT_END));

endmodule

// File: tb/tb_akuma_motion_ctrl.sv
// Bench for akuma_motion_ctrl: directed scenarios plus randomized key traffic,
// every tick compared against a frame-level behavioural model.
module tb_akuma_motion_ctrl;

   localparam logic [5:0] K_NONE  = 6'b000000;
   localparam logic [5:0] K_LEFT  = 6'b000001;
   localparam logic [5:0] K_RIGHT = 6'b000010;
   localparam logic [5:0] K_UP    = 6'b000100;
   localparam logic [5:0] K_PUNCH = 6'b010000;
   localparam logic [5:0] K_DEAD  = 6'b100000;

   logic       vga_clk = 1'b0;
   logic       reset_n = 1'b1;
   logic       frame_tick = 1'b0;
   logic       key_left = 1'b0, key_right = 1'b0, key_up = 1'b0;
   logic       key_down = 1'b0, key_punch = 1'b0, health_zero = 1'b0;
   logic [2:0] sprite;
   logic [9:0] AkumaX, AkumaY;
   logic       attack_active, airborne;

   int checks = 0;
   int failures = 0;

   // Model of the character in frame units: pose code, position, speed, punch age.
   int m_pose, m_x, m_y, m_vel, m_age, m_drift;
   bit m_air;

   akuma_motion_ctrl dut (
      .vga_clk(vga_clk), .reset_n(reset_n), .frame_tick(frame_tick),
      .key_left(key_left), .key_right(key_right), .key_up(key_up),
      .key_down(key_down), .key_punch(key_punch), .health_zero(health_zero),
      .sprite(sprite), .AkumaX(AkumaX), .AkumaY(AkumaY),
      .attack_active(attack_active), .airborne(airborne)
   );

   always #5 vga_clk = ~vga_clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      if (observed != expected) begin
         failures++;
         $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   function automatic int limitX(input int v);
      return (v < 0) ? 0 : ((v > 560) ? 560 : v);
   endfunction

   task automatic modelReset();
      m_pose = 0; m_x = 100; m_y = 300; m_vel = 0; m_age = 0; m_drift = 0; m_air = 0;
   endtask

   // Returns 1 when the feet would reach the ground this frame.
   task automatic modelFly(output bit landed);
      landed = (m_y - m_vel >= 300);
      if (landed) begin
         m_y = 300; m_vel = 0; m_air = 0;
      end else begin
         m_y = m_y - m_vel; m_vel = m_vel - 1;
      end
   endtask

   task automatic modelTick(input logic [5:0] k);
      bit landed;
      bit l, r, u, d, p, h;
      {h, p, d, u, r, l} = k;
      if (m_pose == 0 || m_pose == 3 || m_pose == 4 || m_pose == 5) begin
         if (h) m_pose = 6;
         else if (u) begin
            m_pose = 2; m_vel = 12; m_air = 1; m_drift = int'(r) - int'(l);
         end
         else if (p) begin m_pose = 1; m_age = 0; end
         else if (d) m_pose = 3;
         else if (l && !r) begin m_pose = 4; m_x = limitX(m_x - 2); end
         else if (r && !l) begin m_pose = 5; m_x = limitX(m_x + 2); end
         else m_pose = 0;
      end else if (m_pose == 1) begin
         if (h) m_pose = 6;
         else if (m_age == 11) m_pose = 0;
         else m_age++;
      end else if (m_pose == 2 || m_pose == 7) begin
         modelFly(landed);
         m_x = limitX(m_x + 2 * m_drift);
         if (h) m_pose = 6;
         else if (landed) m_pose = 0;
         else if (p) m_pose = 7;
      end else begin
         if (m_air) modelFly(landed);
      end
   endtask

   task automatic checkAll(input string tag);
      checkOutput({tag, "_sprite"}, int'(sprite), m_pose);
      checkOutput({tag, "_x"}, int'(AkumaX), m_x);
      checkOutput({tag, "_y"}, int'(AkumaY), m_y);
      checkOutput({tag, "_attack"}, int'(attack_active),
                  int'((m_pose == 7) || (m_pose == 1 && m_age >= 4 && m_age <= 8)));
      checkOutput({tag, "_airborne"}, int'(airborne), int'(m_air));
   endtask

   task automatic driveKeys(input logic [5:0] k);
      {health_zero, key_punch, key_down, key_up, key_right, key_left} = k;
   endtask

   // One frame: keys presented with frame_tick, outputs checked a cycle later,
   // sometimes followed by an idle cycle with scrambled keys that must not matter.
   task automatic applyStimulus(input logic [5:0] k, input string tag);
      @(negedge vga_clk);
      driveKeys(k);
      frame_tick = 1'b1;
      @(negedge vga_clk);
      frame_tick = 1'b0;
      modelTick(k);
      checkAll(tag);
      if ($urandom_range(0, 1) == 1) begin
         driveKeys(6'($urandom));
         @(negedge vga_clk);
         checkAll("hold");
      end
   endtask

   task automatic doReset();
      @(negedge vga_clk);
      reset_n = 1'b0;
      frame_tick = 1'b1;
      driveKeys(6'($urandom));
      repeat (3) @(negedge vga_clk);
      reset_n = 1'b1;
      frame_tick = 1'b0;
      modelReset();
      checkAll("reset");
   endtask

   initial begin
      logic [5:0] k;
      int run;
      modelReset();

      doReset();
      checkOutput("rst_sprite", int'(sprite), 0);
      checkOutput("rst_x", int'(AkumaX), 100);
      checkOutput("rst_y", int'(AkumaY), 300);
      checkOutput("rst_attack", int'(attack_active), 0);

      for (int i = 0; i < 10; i++) applyStimulus(K_RIGHT, "walk");
      checkOutput("walk10_x", int'(AkumaX), 120);
      checkOutput("walk10_sprite", int'(sprite), 5);
      for (int i = 0; i < 225; i++) applyStimulus(K_RIGHT, "wall_r");
      checkOutput("wall_r_x", int'(AkumaX), 560);
      checkOutput("wall_r_sprite", int'(sprite), 5);
      applyStimulus(K_LEFT | K_RIGHT, "both");
      checkOutput("both_sprite", int'(sprite), 0);
      checkOutput("both_x", int'(AkumaX), 560);
      for (int i = 0; i < 285; i++) applyStimulus(K_LEFT, "wall_l");
      checkOutput("wall_l_x", int'(AkumaX), 0);
      checkOutput("wall_l_sprite", int'(sprite), 4);

      doReset();
      applyStimulus(K_UP | K_RIGHT, "takeoff");
      checkOutput("takeoff_y", int'(AkumaY), 300);
      for (int t = 1; t <= 25; t++) begin
         applyStimulus(K_NONE, "jump");
         if (t == 12) checkOutput("apex_y", int'(AkumaY), 222);
         if (t == 24) checkOutput("prelanding_sprite", int'(sprite), 2);
      end
      checkOutput("land_y", int'(AkumaY), 300);
      checkOutput("land_sprite", int'(sprite), 0);
      checkOutput("land_x", int'(AkumaX), 150);

      doReset();
      applyStimulus(K_UP, "jatk_takeoff");
      for (int t = 1; t <= 25; t++) begin
         applyStimulus((t == 5) ? K_PUNCH : K_NONE, "jatk");
         if (t == 5 || t == 24) begin
            checkOutput("jatk_sprite", int'(sprite), 7);
            checkOutput("jatk_attack", int'(attack_active), 1);
         end
      end
      checkOutput("jatk_land_sprite", int'(sprite), 0);
      checkOutput("jatk_land_attack", int'(attack_active), 0);
      checkOutput("jatk_land_y", int'(AkumaY), 300);

      applyStimulus(K_PUNCH, "punch_entry");
      checkOutput("punch_entry_sprite", int'(sprite), 1);
      for (int c = 1; c <= 11; c++) begin
         applyStimulus(6'($urandom) & 6'b011111, "punch");
         checkOutput("punch_sprite", int'(sprite), 1);
         checkOutput("punch_window", int'(attack_active), int'(c >= 4 && c <= 8));
      end
      applyStimulus(6'($urandom) & 6'b011111, "punch_end");
      checkOutput("punch_end_sprite", int'(sprite), 0);

      applyStimulus(K_PUNCH, "punch_again");
      for (int c = 0; c < 5; c++) applyStimulus(K_NONE, "punch_mid");
      doReset();
      checkOutput("midpunch_rst_sprite", int'(sprite), 0);
      checkOutput("midpunch_rst_attack", int'(attack_active), 0);

      applyStimulus(K_UP, "die_takeoff");
      for (int t = 1; t <= 5; t++) applyStimulus(K_NONE, "die_rise");
      applyStimulus(K_DEAD, "die");
      checkOutput("die_sprite", int'(sprite), 6);
      checkOutput("die_y", int'(AkumaY), 243);
      for (int t = 0; t < 30; t++) applyStimulus(6'($urandom), "dead");
      checkOutput("dead_sprite", int'(sprite), 6);
      checkOutput("dead_x", int'(AkumaX), 100);
      checkOutput("dead_y", int'(AkumaY), 300);
      checkOutput("dead_airborne", int'(airborne), 0);

      doReset();
      for (int n = 0; n < 300; n++) begin
         k = 6'($urandom) & 6'b011111;
         if ($urandom_range(0, 3) == 0) k = k & 6'b000011;
         if ($urandom_range(0, 199) == 0) k[5] = 1'b1;
         run = $urandom_range(1, 12);
         for (int r = 0; r < run; r++) applyStimulus(k, "rand");
         if ($urandom_range(0, 39) == 0) doReset();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
